// File: rtl/rr_req_queue_2.sv
// Two-channel FIFO front-end for a 2-way round-robin arbiter; pops the granted channel, registered output 1 cycle after gnt.
// Per-channel in_ready = FIFO not full (registered state only); no output backpressure. RR_REQ_QUEUE_COUNT_EN adds occ0/occ1.
module rr_req_queue_2 #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in0_valid,
    input  logic [DW-1:0] in0_data,
    output logic          in0_ready,
    input  logic          in1_valid,
    input  logic [DW-1:0] in1_data,
    output logic          in1_ready,
    output logic [1:0]    req,
    input  logic [1:0]    gnt,
`ifdef RR_REQ_QUEUE_COUNT_EN
    output logic [CW-1:0] occ0,
    output logic [CW-1:0] occ1,
`endif
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_ch
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DW-1:0] mem_q [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] rd_ptr_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [DW-1:0] in_dat [2];
    logic [1:0]    in_vld;
    logic [1:0]    not_full;
    logic [1:0]    not_empty;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic          pop_ok;
    logic          pop_ch;

    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          out_ch_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_vld    = {in1_valid, in0_valid};
        in_dat[0] = in0_data;
        in_dat[1] = in1_data;
        for (int c = 0; c < 2; c++) begin
            not_full[c]  = (cnt_q[c] != FULL_CNT);
            not_empty[c] = (cnt_q[c] != '0);
        end
        // Only a one-hot grant to a non-empty channel pops; anything else is ignored.
        pop[0] = (gnt == 2'b01) && not_empty[0];
        pop[1] = (gnt == 2'b10) && not_empty[1];
        pop_ok = |pop;
        pop_ch = pop[1];
        for (int c = 0; c < 2; c++) begin
            push[c]     = in_vld[c] && not_full[c];
            wr_ptr_d[c] = push[c] ? ptr_inc(wr_ptr_q[c]) : wr_ptr_q[c];
            rd_ptr_d[c] = pop[c]  ? ptr_inc(rd_ptr_q[c]) : rd_ptr_q[c];
            case ({push[c], pop[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
                2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
                default: cnt_d[c] = cnt_q[c];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            out_valid_q <= pop_ok;
            if (pop_ok) begin
                out_data_q <= mem_q[pop_ch][rd_ptr_q[pop_ch]];
                out_ch_q   <= pop_ch;
            end
        end
    end

    // Storage needs no reset: entries are only read when the count says they are valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= in_dat[c];
            end
        end
    end

    assign in0_ready = not_full[0];
    assign in1_ready = not_full[1];
    assign req       = not_empty;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

`ifdef RR_REQ_QUEUE_COUNT_EN
    assign occ0 = cnt_q[0];
    assign occ1 = cnt_q[1];
`endif

endmodule

// File: doc/rr_req_queue_2.md
Name: rr_req_queue_2

Overview:
- Two-channel request front-end that sits directly upstream of the 2-way round-robin arbiter.
- Each channel buffers incoming requests in its own FIFO and presents "non-empty" as req[1:0] to the arbiter.
- It pops the channel named by the arbiter's one-hot gnt[1:0].
- It forwards the popped entry, tagged with its channel number, on a registered output one cycle later.

Parameters:
- DW, 8, data width of each request payload.
- DEPTH, 4, entries per channel FIFO; legal range 2..16; any integer (not required to be a power of two).
- CW, $clog2(DEPTH+1), width of occupancy counters (derived; not to be overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in0_valid  input  1  channel 0 write request.
- in0_data  input  DW  channel 0 payload.
- in0_ready  output  1  channel 0 can accept (FIFO not full).
- in1_valid  input  1  channel 1 write request.
- in1_data  input  DW  channel 1 payload.
- in1_ready  output  1  channel 1 can accept.
- req  output  2  to arbiter; req[i] = channel i FIFO non-empty.
- gnt  input  2  from arbiter; one-hot pop select, valid in the same cycle as req.
- out_valid  output  1  registered; popped entry available this cycle.
- out_data  output  DW  registered payload of popped entry.
- out_ch  output  1  registered channel index of popped entry.

Behaviour:
- Reset, with rst high at a clk edge:
  - Both FIFOs are emptied: pointers and counts go to 0.
  - out_valid=0, out_data=0, out_ch=0.
  - req=00, in0_ready=in1_ready=1 in the cycle after reset.
  - Reset asserted mid-operation discards all buffered entries; nothing in flight is delivered.
- Per-channel FIFO:
  - Circular buffer with wr_ptr, rd_ptr, count.
  - Pointers wrap from DEPTH-1 to 0.
- Push: in_valid & in_ready at the edge writes data at wr_ptr, then increments wr_ptr.
- in_ready:
  - in_ready = (count != DEPTH), derived only from registered state.
  - No combinational path from gnt to in_ready.
  - A full FIFO refuses a push even in a cycle where it is popped.
- Pop: gnt[i]=1 and count_i != 0 at the edge reads rd_ptr and increments it.
- Simultaneous push and pop on one channel:
  - Both take effect and count is unchanged.
  - With count=1, the popped entry is the old head and the pushed entry becomes the new head.
  - There is no same-cycle bypass: an entry pushed into an empty FIFO is visible on req the next cycle.
- req[i] = (count_i != 0), combinational from registers.
- Output register, updated every clk edge when not in reset:
  - Legal pop (gnt one-hot, granted channel non-empty):
    - out_valid <= 1, out_data <= head of granted channel, out_ch <= granted index.
    - Latency is one cycle from the gnt cycle.
  - Otherwise, out_valid <= 0 and out_data/out_ch hold their previous values.
  - The consumer always accepts; there is no output backpressure.
- Illegal gnt:
  - gnt=11, or gnt to an empty channel, causes no pop on any channel and out_valid <= 0 for that cycle.
  - FIFO state is unchanged apart from pushes.
- Channels are independent: pushes on one channel never affect the other's state.
- Throughput: one pop per cycle total; one push per cycle per channel.

Optional Feature:
- Macro: RR_REQ_QUEUE_COUNT_EN.
- Defined: adds output ports occ0 and occ1, each CW bits, exposing each channel's registered count. They are reset to 0 and update on the same edge as the count.
- Not defined: the ports do not exist, with no other behavioural difference.

Test Plan:
- Reset then idle -> req=00, in0_ready=in1_ready=1, out_valid=0; with the macro defined, occ0=occ1=0.
- Push 0xA1, 0xA2 on ch0 only; arbiter gnt=01 on consecutive cycles -> out_valid=1 with out_data 0xA1 then 0xA2, out_ch=0; req[0] drops to 0 the cycle after the second pop.
- Fill ch1 with 4 entries 0xB0..0xB3 (DEPTH=4) -> in1_ready=0; assert in1_valid with 0xFF alongside gnt=10 -> 0xFF not stored; out_data=0xB0; in1_ready=1 next cycle.
- Both channels loaded, driven by the round-robin arbiter with req=11 sustained -> out_ch alternates 1,0,1,0 and payload order per channel is preserved; wrap past DEPTH-1 is exercised with 10 entries per channel.
- Drive gnt=11, then gnt=01 with ch0 empty -> no pop, out_valid=0, counts unchanged.
- Assert rst with 3 entries in ch0 and out_valid=1 -> next cycle out_valid=0, req=00; a later pop returns only data pushed after reset.
